// File: rtl/asi_pkg.sv
// asi_pkg: shared ASI slave widths, wait states and byte-lane mask helper
// Contents:
//   AXI_AW/AXI_DW/AXI_SW  bus address, data and size widths
//   SLV_BYTEW, SLV_LG     bytes per data word and its log2
//   SLV_WS                read wait states (latency from request to data)
//   lane_mask()           byte lanes touched by a beat, shared by read and write paths
package asi_pkg;
   localparam int AXI_AW    = 32;
   localparam int AXI_DW    = 32;
   localparam int AXI_SW    = 3;
   localparam int SLV_BYTEW = AXI_DW / 8;
   localparam int SLV_LG    = $clog2(SLV_BYTEW);
   localparam int SLV_WS    = 2;

   // Lanes lo..lo+2^size-1 with lo the size-aligned offset; oversize beats keep every lane
   function automatic logic [SLV_BYTEW-1:0] lane_mask(input logic [SLV_LG-1:0] lo_addr,
                                                      input logic [AXI_SW-1:0] size);
      logic [SLV_BYTEW-1:0] m;
      int lo, n;
      m = '1;
      if (int'(size) <= SLV_LG) begin
         n  = 1 << size;
         lo = int'(lo_addr) & ~(n - 1);
         for (int i = 0; i < SLV_BYTEW; i++) m[i] = (i >= lo) && (i < lo + n);
      end
      return m;
   endfunction
endpackage

// File: rtl/asi_rd_mem_if.sv
// asi_rd_mem_if: read-beat request/response bundle between asi_r and the SRAM read port
// Signals:
//   m_re, m_raddr, m_rsize       request: one beat per cycle, byte address, log2 byte count
//   m_rdata, m_rvalid, m_rslverr response: lane-masked data, valid, out-of-range flag
// Modports: master drives requests, slave drives responses.
interface asi_rd_mem_if;
   import asi_pkg::*;
   logic              m_re;
   logic [AXI_AW-1:0] m_raddr;
   logic [AXI_SW-1:0] m_rsize;
   logic [AXI_DW-1:0] m_rdata;
   logic              m_rvalid;
   logic              m_rslverr;
   modport master (output m_re, m_raddr, m_rsize, input m_rdata, m_rvalid, m_rslverr);
   modport slave  (input m_re, m_raddr, m_rsize, output m_rdata, m_rvalid, m_rslverr);
endinterface

// File: rtl/asi_rd_pipe.sv
// asi_rd_pipe: valid/data delay line of depth N with async active-low reset
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_data    stage input
//   out_valid, out_data  input delayed by N cycles
//   any_valid            OR of every stage valid bit
module asi_rd_pipe #(
   parameter int N = 1,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         any_valid
);
   logic [N-1:0] v;
   logic [W-1:0] d [N];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v <= '0;
         for (int i = 0; i < N; i++) d[i] <= '0;
      end else begin
         v[0] <= in_valid;
         d[0] <= in_data;
         for (int i = 1; i < N; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
         end
      end
   assign out_valid = v[N-1];
   assign out_data  = d[N-1];
   assign any_valid = |v;
endmodule

// File: rtl/asi_rd_mem.sv
// asi_rd_mem: SRAM-backed read slave for asi_r with an SLV_WS-cycle fixed-latency pipeline
// Ports:
//   usr_clk, usr_reset_n   clock, asynchronous active-low reset
//   bus (slave)            read requests in, lane-masked data/valid/slverr out
//   mem_ce, mem_addr       SRAM read enable and word address (stage 0, combinational)
//   mem_q                  SRAM data, valid one cycle after mem_ce
//   err_cnt                saturating count of slverr beats
//   busy                   a request is presented or any beat is in flight
// Build option: define ASI_RD_ADDR_CHECK_EN to flag beats outside the SRAM window as
// slverr; otherwise addresses wrap onto the SRAM by truncation.
module asi_rd_mem
   import asi_pkg::*;
#(
   parameter int                MEM_DEPTH = 256,
   parameter logic [AXI_AW-1:0] MEM_BASE  = '0
) (
   input  logic                         usr_clk,
   input  logic                         usr_reset_n,
   asi_rd_mem_if.slave                  bus,
   output logic                         mem_ce,
   output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
   input  logic [AXI_DW-1:0]            mem_q,
   output logic [15:0]                  err_cnt,
   output logic                         busy
);
   localparam int AW = $clog2(MEM_DEPTH);
   logic                 oor;
   logic                 s1_valid, s1_oor, p_busy;
   logic [SLV_BYTEW-1:0] s1_mask;
   logic [AXI_DW-1:0]    s1_data;
`ifdef ASI_RD_ADDR_CHECK_EN
   // One extra bit so a window ending at the top of the address space does not wrap
   localparam logic [AXI_AW:0] MEM_END = {1'b0, MEM_BASE} + (AXI_AW+1)'(MEM_DEPTH * SLV_BYTEW);
   assign oor = (bus.m_raddr < MEM_BASE) | ({1'b0, bus.m_raddr} >= MEM_END);
`else
   assign oor = 1'b0;
`endif
   assign mem_ce   = bus.m_re & ~oor;
   assign mem_addr = AW'((bus.m_raddr - MEM_BASE) >> SLV_LG);
   always_ff @(posedge usr_clk or negedge usr_reset_n)
      if (!usr_reset_n) begin
         s1_valid <= 1'b0;
         s1_oor   <= 1'b0;
         s1_mask  <= '0;
      end else begin
         s1_valid <= bus.m_re;
         s1_oor   <= bus.m_re & oor;
         s1_mask  <= lane_mask(bus.m_raddr[SLV_LG-1:0], bus.m_rsize);
      end
   // Idle and out-of-range beats carry zero so stale mem_q never leaks out
   always_comb begin
      s1_data = '0;
      for (int i = 0; i < SLV_BYTEW; i++)
         s1_data[8*i +: 8] = (s1_valid && !s1_oor && s1_mask[i]) ? mem_q[8*i +: 8] : 8'h00;
   end
   generate
      if (SLV_WS < 1) begin : g_bad
         $error("asi_rd_mem: SLV_WS must be at least 1");
      end else if (SLV_WS == 1) begin : g_ws1
         assign bus.m_rvalid  = s1_valid;
         assign bus.m_rslverr = s1_valid & s1_oor;
         assign bus.m_rdata   = s1_data;
         assign p_busy        = 1'b0;
      end else begin : g_wsn
         logic [AXI_DW:0] p_data;
         asi_rd_pipe #(.N(SLV_WS - 1), .W(AXI_DW + 1)) u_pipe (
            .clk      (usr_clk),
            .rst_n    (usr_reset_n),
            .in_valid (s1_valid),
            .in_data  ({s1_oor, s1_data}),
            .out_valid(bus.m_rvalid),
            .out_data (p_data),
            .any_valid(p_busy)
         );
         assign bus.m_rdata   = p_data[AXI_DW-1:0];
         assign bus.m_rslverr = bus.m_rvalid & p_data[AXI_DW];
      end
   endgenerate
   always_ff @(posedge usr_clk or negedge usr_reset_n)
      if (!usr_reset_n) err_cnt <= '0;
      else if (bus.m_rvalid && bus.m_rslverr && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
   assign busy = bus.m_re | s1_valid | p_busy;
endmodule

// File: tb/tb_asi_rd_mem.sv
// tb_asi_rd_mem: scoreboard bench for asi_rd_mem with a byte-level reference model
module tb_asi_rd_mem;
   import asi_pkg::*;
   localparam int          DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0;
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;
   logic        usr_clk = 1'b0;
   logic        usr_reset_n = 1'b0;
   logic        mem_ce;
   logic [7:0]  mem_addr;
   logic [31:0] mem_q = '0;
   logic [15:0] err_cnt;
   logic        busy;
   logic [31:0] mem_arr [DEPTH];
   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int          exp_err = 0;
   int          cyc = 0;

   asi_rd_mem_if bus();
   asi_rd_mem #(.MEM_DEPTH(DEPTH), .MEM_BASE(BASE)) dut (
      .usr_clk    (usr_clk),
      .usr_reset_n(usr_reset_n),
      .bus        (bus),
      .mem_ce     (mem_ce),
      .mem_addr   (mem_addr),
      .mem_q      (mem_q),
      .err_cnt    (err_cnt),
      .busy       (busy)
   );

   always #5 usr_clk = ~usr_clk;
   always @(posedge usr_clk) cyc <= cyc + 1;
   always @(posedge usr_clk) if (mem_ce) mem_q <= mem_arr[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 20) $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_oor(input logic [31:0] a);
`ifdef ASI_RD_ADDR_CHECK_EN
      return (a < BASE) || (a >= BASE + DEPTH * 4);
`else
      return (a != a);
`endif
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'(((a - BASE) / 4) % DEPTH);
   endfunction

   // Bytes kept: the 2^size-byte naturally aligned chunk holding the address; oversize = whole word
   function automatic logic [31:0] model(input logic [31:0] a, input int size);
      logic [31:0] w, r;
      int nb, start;
      r = '0;
      if (is_oor(a)) return r;
      w     = mem_arr[word_of(a)];
      nb    = (size > 2) ? 4 : (1 << size);
      start = (size > 2) ? 0 : int'(a % 4) / nb * nb;
      for (int b = 0; b < 4; b++) if (b >= start && b < start + nb) r[8*b +: 8] = w[8*b +: 8];
      return r;
   endfunction

   task automatic beat(input logic [31:0] a, input int size, input logic [31:0] ed, input logic ee);
      @(negedge usr_clk);
      bus.m_re    = 1'b1;
      bus.m_raddr = a;
      bus.m_rsize = 3'(size);
      sb.push_back('{ed, ee, cyc + SLV_WS});
      #1;
      chk("mem_ce", {31'd0, mem_ce}, {31'd0, !ee});
      if (!ee) chk("mem_addr", {24'd0, mem_addr}, word_of(a));
      chk("busy", {31'd0, busy}, 32'd1);
   endtask

   task automatic mbeat(input logic [31:0] a, input int size);
      beat(a, size, model(a, size), is_oor(a));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge usr_clk);
         bus.m_re = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      idle(1);
      while (sb.size() != 0 && k < 40) begin
         idle(1);
         k++;
      end
      chk("drain", sb.size(), 0);
      idle(1);
   endtask

   always @(negedge usr_clk) begin
      exp_t e;
      chk("err_cnt", {16'd0, err_cnt}, exp_err);
      if (bus.m_rvalid) begin
         if (sb.size() == 0) chk("spurious_rvalid", {31'd0, bus.m_rvalid}, 32'd0);
         else begin
            e = sb.pop_front();
            chk("rdata", bus.m_rdata, e.data);
            chk("rslverr", {31'd0, bus.m_rslverr}, {31'd0, e.err});
            chk("latency", cyc, e.cyc);
            if (e.err && exp_err < 65535) exp_err++;
         end
      end else chk("rslverr_idle", {31'd0, bus.m_rslverr}, 32'd0);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] = $urandom;
      mem_arr[4]  = 32'hAABBCCDD;
      mem_arr[1]  = 32'h11223344;
      bus.m_re    = 1'b0;
      bus.m_raddr = '0;
      bus.m_rsize = '0;
      repeat (2) @(negedge usr_clk);
      chk("rst_rvalid", {31'd0, bus.m_rvalid}, 32'd0);
      chk("rst_rdata", bus.m_rdata, 32'd0);
      chk("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      usr_reset_n = 1'b1;
      beat(32'h10, 2, 32'hAABBCCDD, 1'b0);
      drain();
      beat(32'h13, 0, 32'hAA000000, 1'b0);
      beat(32'h12, 1, 32'hAABB0000, 1'b0);
      drain();
      for (int i = 0; i < 8; i++) mbeat(32'(i * 4), 2);
      drain();
`ifdef ASI_RD_ADDR_CHECK_EN
      beat(32'h400, 2, 32'h0, 1'b1);
      drain();
      chk("err_cnt_one", {16'd0, err_cnt}, 32'd1);
`else
      beat(32'h404, 2, 32'h11223344, 1'b0);
      drain();
      chk("err_cnt_zero", {16'd0, err_cnt}, 32'd0);
`endif
      repeat (400) begin
         if ($urandom_range(3) == 0) idle(1);
         mbeat(32'($urandom_range(32'h4FF)), int'($urandom_range(3)));
      end
      drain();
      for (int i = 0; i < 3; i++) mbeat(32'h20 + 32'(i * 4), 2);
      @(posedge usr_clk);
      #1;
      usr_reset_n = 1'b0;
      bus.m_re    = 1'b0;
      sb.delete();
      exp_err     = 0;
      #1;
      chk("rst_mid_rvalid", {31'd0, bus.m_rvalid}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_err_cnt", {16'd0, err_cnt}, 32'd0);
      repeat (2) @(negedge usr_clk);
      usr_reset_n = 1'b1;
      beat(32'h10, 2, 32'hAABBCCDD, 1'b0);
      drain();
`ifdef ASI_RD_ADDR_CHECK_EN
      repeat (65540) beat(32'h400, 2, 32'h0, 1'b1);
      drain();
      chk("err_cnt_sat", {16'd0, err_cnt}, 32'h0000FFFF);
`endif
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
